systolic_mac_array: RTL and testbench
=====================================

Name: systolic_mac_array

Overview:
Parametrised N×N output-stationary systolic MAC array. It is the next generation of the fixed 2×2 MAC block.
- Each input beat carries one N-wide A vector (rows) and one N-wide B vector (columns).
- Each PE(i,j) accumulates a_i*b_j over k_len beats; the result is the outer-product sum C = Σ a(t)·b(t)ᵀ.
- Adds a valid/ready input stream, internal skew, a start/drain/done FSM, a signed/unsigned mode and a held, back-pressurable result.
- Sits between the operand-fetch buffers and the result writeback in the accelerator datapath.

Parameters:
N, 2, array dimension (rows = columns = N), legal 1..8
DW, 32, operand width per lane
AW, 64, accumulator width, must be >= 2*DW
KW, 16, width of k_len

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-low (rst==0 at a clk edge resets)
start  in  1  begin a new job; sampled only in IDLE
k_len  in  KW  number of beats in the job; captured on start
signed_mode  in  1  1 = two's-complement operands; captured on start
in_valid  in  1  operand beat valid
in_ready  out  1  array accepts a beat
a_vec  in  N*DW  lane i = a_i at [i*DW +: DW]
b_vec  in  N*DW  lane j = b_j at [j*DW +: DW]
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts the result
c_flat  out  N*N*AW  C[i][j] at [(i*N+j)*AW +: AW], row-major
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst==0 at an edge):
  - FSM goes to IDLE.
  - All accumulators, skew registers, valid pipes and counters clear.
  - in_ready=0, out_valid=0, c_flat=0, busy=0.
  - A reset mid-job aborts the job; no partial result is ever presented.
- FSM states: IDLE, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 captures k_len and signed_mode and clears all accumulators the same cycle.
  - Next state is COMPUTE, or DRAIN if k_len==0.
- COMPUTE:
  - in_ready=1.
  - A beat is accepted on any edge with in_valid & in_ready.
  - in_valid=0 cycles are bubbles; they do not accumulate and do not count.
  - After the k_len-th accepted beat the FSM goes to DRAIN and in_ready falls on the next cycle.
- DRAIN:
  - in_ready=0; lasts exactly 2N-1 cycles (down-counter), then goes to DONE.
  - For k_len==0, DRAIN still lasts 2N-1 cycles and the result is all zeros.
- DONE:
  - out_valid=1 and c_flat holds stable until out_ready=1 at an edge, then the FSM returns to IDLE.
  - out_valid falls the cycle after the handshake.
- Latency: out_valid rises exactly 2N cycles after the edge that accepts the final beat.
- Skew and datapath:
  - Row lane i is delayed i cycles and column lane j is delayed j cycles, each with a per-lane valid bit.
  - A and its valid move right; B and its valid move down.
  - PE(i,j) accumulates when its a-valid and b-valid are both set; they are always coincident by construction.
- Arithmetic:
  - Product is 2*DW bits, signed or unsigned per the captured signed_mode.
  - The product is sign- or zero-extended to AW, and the accumulator wraps modulo 2^AW.
  - No saturation and no overflow flag.
- start while not IDLE is ignored. start coincident with reset is ignored (reset wins).
- out_ready outside DONE is ignored. in_valid outside COMPUTE is ignored, and no beat is lost silently because in_ready=0 there.
- c_flat is registered and reflects the accumulators only when out_valid=1; otherwise it holds its last value (0 after reset).

Decomposition:
- Package mac_array_pkg holds:
  - the state enum (IDLE/COMPUTE/DRAIN/DONE);
  - localparams for drain length (2N-1) and skew depth (N-1);
  - the lane-slice helper functions for a_vec, b_vec and c_flat indexing.
- One sub-module, mac_pe:
  - inputs: a_in, b_in, v_in, clr, signed_mode;
  - outputs: a_out, b_out, v_out registered, plus acc.
- The top module generates the N×N grid, the skew shift registers and the FSM/counters.

Test Plan:
- N=2, unsigned, k_len=1, a=(10,5), b=(2,3) -> after 2N=4 cycles out_valid=1, C00=20, C01=30, C10=10, C11=15.
- k_len=3 with bubbles, beats a=(1,2),b=(3,4); a=(2,0),b=(1,1); a=(1,1),b=(2,2), two in_valid=0 cycles interleaved -> C00=7, C01=8, C10=8, C11=10; in_ready drops after beat 3.
- signed_mode=1, k_len=1, a=(-3,7), b=(4,-2) -> C00=-12, C01=6, C10=28, C11=-14, all sign-extended to 64 bits.
- out_ready held 0 for 10 cycles in DONE -> out_valid and c_flat stable throughout; start pulsed then is ignored; handshake returns the FSM to IDLE.
- Reset (rst=0) asserted mid-COMPUTE after 1 beat -> next edge busy=0, in_ready=0, out_valid=0, c_flat=0; a fresh job then gives correct results with no residue.
- Overflow and edges: unsigned, k_len=2, a0=b0=0xFFFFFFFF on both beats -> C00=2*(0xFFFFFFFE00000001) mod 2^64 = 0xFFFFFFFC00000002. Also k_len=0 -> all zeros, with out_valid 2N-1 cycles after the DRAIN entry.

Source files
------------

// File: rtl/mac_array_pkg.sv
// mac_array_pkg: shared types and helpers for the systolic MAC array.
//   state_e     - job FSM states
//   drain_len   - cycles spent in DRAIN for an n x n grid (2n-1)
//   skew_depth  - deepest input skew line for an n x n grid (n-1)
//   lane_lo     - low bit of lane idx in a flat vector of w-bit lanes
//   c_lo        - low bit of C[i][j] in the row-major flat result
package mac_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int skew_depth(input int n);
    return n - 1;
  endfunction

  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

  function automatic int c_lo(input int i, input int j, input int n, input int aw);
    return (i * n + j) * aw;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// mac_pe: one processing element of the output-stationary grid.
//   clk, rst      - clock, synchronous active-low reset
//   clr           - zero the accumulator (start of a job)
//   signed_mode   - 1: operands are two's complement
//   a_in, b_in    - operands arriving from the left / from above
//   v_in          - {b_valid, a_valid} travelling with the operands
//   a_out, b_out  - registered operands forwarded right / down
//   v_out         - registered valids forwarded with them
//   acc           - running sum of a*b, wraps modulo 2^AW
module mac_pe #(
  parameter int DW = 32,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          signed_mode,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [1:0]    v_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [1:0]    v_out,
  output logic [AW-1:0] acc
);

  // Bits of the accumulator above the raw product; empty when AW == 2*DW.
  localparam logic [AW-1:0] HI_MASK = ~AW'({(2 * DW){1'b1}});

  logic [2*DW-1:0] op_a, op_b, prod;
  logic [AW-1:0]   prod_ext;
  logic [AW-1:0]   acc_d, acc_q;
  logic [DW-1:0]   a_d, a_q, b_d, b_q;
  logic [1:0]      v_d, v_q;

  always_comb begin
    // Extending both operands to 2*DW first makes one unsigned multiplier
    // produce the correct low 2*DW bits for either signedness.
    if (signed_mode) begin
      op_a = {{DW{a_in[DW-1]}}, a_in};
      op_b = {{DW{b_in[DW-1]}}, b_in};
    end else begin
      op_a = {{DW{1'b0}}, a_in};
      op_b = {{DW{1'b0}}, b_in};
    end
    prod     = op_a * op_b;
    prod_ext = AW'(prod);
    if (signed_mode && prod[2*DW-1]) prod_ext = prod_ext | HI_MASK;

    acc_d = acc_q;
    if (clr)                acc_d = '0;
    else if (v_in == 2'b11) acc_d = acc_q + prod_ext;

    a_d = a_in;
    b_d = b_in;
    v_d = v_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      v_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      v_q   <= v_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign v_out = v_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// systolic_mac_array: N x N output-stationary MAC array, C = sum a(t) b(t)^T.
//   clk, rst        - clock, synchronous active-low reset
//   start, k_len    - launch a job of k_len beats (sampled in IDLE)
//   signed_mode     - operand signedness, captured on start
//   in_valid/ready  - operand beat handshake; a_vec/b_vec lane i at [i*DW +: DW]
//   out_valid/ready - result handshake; c_flat holds C[i][j] at [(i*N+j)*AW +: AW]
//   busy            - job in progress (any state but IDLE)
module systolic_mac_array
  import mac_array_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 32,
  parameter int AW = 64,
  parameter int KW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_vec,
  input  logic [N*DW-1:0]   b_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] c_flat,
  output logic              busy
);

  localparam int DRAIN_LEN = drain_len(N);
  localparam int SKEW      = skew_depth(N);
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  state_e             state_q, state_d;
  logic [KW-1:0]      k_len_q, k_len_d;
  logic [KW-1:0]      cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [N*N*AW-1:0]  c_flat_q, c_flat_d;

  logic               clr;
  logic               beat_acc;
  logic [N*N*AW-1:0]  acc_flat;

  // Skewed lane outputs feeding the left column / top row of the grid.
  logic [DW-1:0] a_sk  [N];
  logic [DW-1:0] b_sk  [N];
  logic          va_sk [N];
  logic          vb_sk [N];

  logic [DW-1:0] pe_a [N][N];
  logic [DW-1:0] pe_b [N][N];
  logic [1:0]    pe_v [N][N];
  logic [AW-1:0] acc_arr [N*N];

  assign clr      = (state_q == ST_IDLE) && start;
  assign beat_acc = (state_q == ST_COMPUTE) && in_ready_q && in_valid;

  // ---------------- FSM ----------------
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    drain_d     = drain_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    c_flat_d    = c_flat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d  = k_len;
          signed_d = signed_mode;
          cnt_d    = '0;
          if (k_len == '0) begin
            state_d = ST_DRAIN;
            drain_d = DCW'(DRAIN_LEN - 1);
          end else begin
            state_d    = ST_COMPUTE;
            in_ready_d = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        // in_ready already low means the last beat went in on the previous
        // edge; that extra cycle makes the result land 2N after it.
        if (!in_ready_q) begin
          state_d = ST_DRAIN;
          drain_d = DCW'(DRAIN_LEN - 1);
        end else if (in_valid) begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_d == k_len_q) in_ready_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          c_flat_d    = acc_flat;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      drain_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      c_flat_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      c_flat_q    <= c_flat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign c_flat    = c_flat_q;

  // ---------------- input skew ----------------
  // Lane 0 enters the grid directly; lane i waits i cycles so that a_i and
  // b_j of the same beat meet in PE(i,j) on the same edge.
  assign a_sk[0]  = a_vec[lane_lo(0, DW) +: DW];
  assign b_sk[0]  = b_vec[lane_lo(0, DW) +: DW];
  assign va_sk[0] = beat_acc;
  assign vb_sk[0] = beat_acc;

  for (genvar i = 1; i <= SKEW; i++) begin : g_skew
    logic [i-1:0][DW-1:0] a_q, a_d, b_q, b_d;
    logic [i-1:0]         va_q, va_d, vb_q, vb_d;

    always_comb begin
      a_d[0]  = a_vec[lane_lo(i, DW) +: DW];
      b_d[0]  = b_vec[lane_lo(i, DW) +: DW];
      va_d[0] = beat_acc;
      vb_d[0] = beat_acc;
      for (int s = 1; s < i; s++) begin
        a_d[s]  = a_q[s-1];
        b_d[s]  = b_q[s-1];
        va_d[s] = va_q[s-1];
        vb_d[s] = vb_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        a_q  <= '0;
        b_q  <= '0;
        va_q <= '0;
        vb_q <= '0;
      end else begin
        a_q  <= a_d;
        b_q  <= b_d;
        va_q <= va_d;
        vb_q <= vb_d;
      end
    end

    assign a_sk[i]  = a_q[i-1];
    assign b_sk[i]  = b_q[i-1];
    assign va_sk[i] = va_q[i-1];
    assign vb_sk[i] = vb_q[i-1];
  end

  // ---------------- PE grid ----------------
  // A and its valid move right along a row, B and its valid move down a column.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in, b_in;
      logic          va_in, vb_in;

      if (j == 0) begin : g_al
        assign a_in  = a_sk[i];
        assign va_in = va_sk[i];
      end else begin : g_ai
        assign a_in  = pe_a[i][j-1];
        assign va_in = pe_v[i][j-1][0];
      end

      if (i == 0) begin : g_bt
        assign b_in  = b_sk[j];
        assign vb_in = vb_sk[j];
      end else begin : g_bi
        assign b_in  = pe_b[i-1][j];
        assign vb_in = pe_v[i-1][j][1];
      end

      mac_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .signed_mode (signed_q),
        .a_in        (a_in),
        .b_in        (b_in),
        .v_in        ({vb_in, va_in}),
        .a_out       (pe_a[i][j]),
        .b_out       (pe_b[i][j]),
        .v_out       (pe_v[i][j]),
        .acc         (acc_arr[i*N+j])
      );
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_flat[c_lo(i, j, N, AW) +: AW] = acc_arr[i*N+j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Scoreboard bench for systolic_mac_array (N=2): the driver pushes the
// hand-computed result and its expected arrival cycle; a negedge monitor
// pops and compares when out_valid first rises.
module tb_systolic_mac_array;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 64;
  localparam int KW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              signed_mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   a_vec = '0;
  logic [N*DW-1:0]   b_vec = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N*N*AW-1:0] c_flat;
  logic              busy;

  systolic_mac_array #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
    .out_ready(out_ready), .c_flat(c_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_acc = 0;
  int start_cyc = 0;

  typedef struct {
    logic [N*N*AW-1:0] c;
    int                at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic seen = 1'b0;

  task automatic chk(input string name, input logic [N*N*AW-1:0] act,
                     input logic [N*N*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*N*AW-1:0] pk(input logic [AW-1:0] c00,
      input logic [AW-1:0] c01, input logic [AW-1:0] c10, input logic [AW-1:0] c11);
    return {c11, c10, c01, c00};
  endfunction

  // Monitor: compare once per result presentation.
  always @(negedge clk) begin
    if (rst && out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h want none", c_flat);
      end else begin
        mon_e = sb.pop_front();
        chk("result", c_flat, mon_e.c);
        chk_i("latency", cyc, mon_e.at);
      end
    end
    if (!out_valid) seen = 1'b0;
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [KW-1:0] k, input logic sm);
    start = 1'b1; k_len = k; signed_mode = sm;
    step;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic beat(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                      input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    int t;
    t = 0;
    a_vec = {a1, a0}; b_vec = {b1, b0}; in_valid = 1'b1;
    while (!in_ready && t < 20) begin step; t++; end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got in_ready=0 want 1");
    end
    step;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic bubble;
    in_valid = 1'b0;
    step;
  endtask

  task automatic wait_result;
    int t;
    t = 0;
    while (!out_valid && t < 50) begin step; t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL result_timeout: got out_valid=0 want 1");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*N*AW-1:0] held;
    rst = 1'b0;
    repeat (3) step;
    chk_i("reset_ctrl", {in_ready, out_valid, busy}, 0);
    chk("reset_c", c_flat, '0);
    rst = 1'b1;
    step;

    // 1: unsigned single beat
    do_start(1, 1'b0);
    beat(10, 5, 2, 3);
    sb.push_back('{pk(20, 30, 10, 15), last_acc + 2 * N});
    wait_result;
    step;
    chk_i("t1_idle", {busy, out_valid}, 0);

    // 2: three beats with bubbles
    do_start(3, 1'b0);
    chk_i("t2_ready_on", in_ready, 1);
    beat(1, 2, 3, 4);
    bubble;
    beat(2, 0, 1, 1);
    bubble;
    beat(1, 1, 2, 2);
    chk_i("t2_ready_drop", in_ready, 0);
    sb.push_back('{pk(7, 8, 8, 10), last_acc + 2 * N});
    wait_result;
    step;

    // 3: signed
    do_start(1, 1'b1);
    beat(-32'sd3, 32'sd7, 32'sd4, -32'sd2);
    sb.push_back('{pk(-64'sd12, 64'sd6, 64'sd28, -64'sd14), last_acc + 2 * N});
    wait_result;
    step;

    // 4: back-pressure hold, start ignored in DONE
    out_ready = 1'b0;
    do_start(1, 1'b0);
    beat(3, 4, 5, 6);
    held = pk(15, 18, 20, 24);
    sb.push_back('{held, last_acc + 2 * N});
    wait_result;
    for (int r = 0; r < 10; r++) begin
      chk_i("hold_valid", out_valid, 1);
      chk("hold_c", c_flat, held);
      start = (r == 3);
      step;
    end
    start = 1'b0;
    out_ready = 1'b1;
    step;
    chk_i("hs_drop", {out_valid, busy}, 0);
    step;
    chk_i("hs_stay_idle", busy, 0);

    // 5: reset mid-compute, then a clean job
    do_start(3, 1'b0);
    beat(1, 1, 1, 1);
    rst = 1'b0;
    step;
    chk_i("abort_ctrl", {busy, in_ready, out_valid}, 0);
    chk("abort_c", c_flat, '0);
    rst = 1'b1;
    step;
    do_start(1, 1'b0);
    beat(10, 5, 2, 3);
    sb.push_back('{pk(20, 30, 10, 15), last_acc + 2 * N});
    wait_result;
    step;

    // 6: accumulator wrap
    do_start(2, 1'b0);
    beat(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0);
    beat(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0);
    sb.push_back('{pk(64'hFFFFFFFC00000002, 0, 0, 0), last_acc + 2 * N});
    wait_result;
    step;

    // 7: k_len == 0
    do_start(0, 1'b0);
    chk_i("k0_no_ready", in_ready, 0);
    sb.push_back('{pk(0, 0, 0, 0), start_cyc + 2 * N - 1});
    wait_result;
    step;

    repeat (5) step;
    chk_i("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
